// File: rtl/lif_sched_if.sv
// lif_sched_if: spike event stream from the LIF scheduler to its consumer.
//   spike_valid : event pending (producer)
//   spike_idx   : index of the spiking neuron (producer)
//   spike_ready : consumer accepts the pending event (consumer)
// Modports: master = scheduler side, slave = consumer side.
interface lif_sched_if #(
  parameter int IDX_W = 3
);
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;
  logic             spike_ready;

  modport master (output spike_valid, output spike_idx, input spike_ready);
  modport slave  (input spike_valid, input spike_idx, output spike_ready);
endinterface

// File: rtl/lif_sched.sv
// lif_sched: time-multiplexed leaky integrate-and-fire scheduler. One update
// datapath is shared by N_NEURONS virtual neurons; each tick sweeps neurons
// 0..N-1 at one per cycle and emits spike events on a valid/ready stream.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   tick        : start-of-timestep pulse
//   stim_we/stim_addr/stim_data : write input current of one neuron
//   thr_we/thr_data             : write the shared firing threshold
//   sp (lif_sched_if.master)    : spike_valid / spike_idx / spike_ready
//   busy        : sweep in progress (SWEEP or FLUSH)
//   done        : one-cycle pulse when the sweep completes
//   overrun     : sticky, a tick arrived while busy
//   spike_count : (only with LIF_SCHED_SPIKE_COUNT_EN) spikes in last sweep
//
// Optional feature macro: LIF_SCHED_SPIKE_COUNT_EN
module lif_sched #(
  parameter int               N_NEURONS  = 8,
  parameter int               WIDTH      = 8,
  parameter int               LEAK_SHIFT = 1,
  parameter logic [WIDTH-1:0] THR_INIT   = 8'd200,
  parameter int               REFRAC     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         stim_we,
  input  logic [$clog2(N_NEURONS)-1:0] stim_addr,
  input  logic [WIDTH-1:0]             stim_data,
  input  logic                         thr_we,
  input  logic [WIDTH-1:0]             thr_data,
  lif_sched_if.master                  sp,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  ,
  output logic [$clog2(N_NEURONS):0]   spike_count
`endif
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [WIDTH-1:0]  thr_q;
  logic              overrun_q;
  logic              vld_p0;
  logic [IW-1:0]     spk_idx_p0;

  logic [WIDTH-1:0]  u_q   [N_NEURONS];
  logic [WIDTH-1:0]  cur_q [N_NEURONS];
  logic [RW-1:0]     ref_q [N_NEURONS];

  logic              stall, proc, last, fire, spike_now;
  logic [WIDTH-1:0]  u_cur, c_cur, v_sat;
  logic [RW-1:0]     ref_cur;
  logic [WIDTH:0]    v_raw;

  // Clamp the WIDTH+1-bit sum back into WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_u(input logic [WIDTH:0] x);
    return x[WIDTH] ? {WIDTH{1'b1}} : x[WIDTH-1:0];
  endfunction

  // ---- shared update datapath (combinational, registered below) ----
  assign u_cur   = u_q[idx_q];
  assign c_cur   = cur_q[idx_q];
  assign ref_cur = ref_q[idx_q];
  assign v_raw   = {1'b0, u_cur} - {1'b0, (u_cur >> LEAK_SHIFT)} + {1'b0, c_cur};
  assign v_sat   = sat_u(v_raw);

  // A held, unaccepted spike blocks the sweep: the single output slot is full.
  assign stall     = vld_p0 && !sp.spike_ready;
  assign proc      = (state_q == SWEEP) && !stall;
  assign last      = (idx_q == IW'(N_NEURONS - 1));
  assign fire      = (ref_cur == '0) && (v_sat >= thr_q);
  assign spike_now = proc && fire;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SWEEP;
      SWEEP:   if (proc && last) state_d = spike_now ? FLUSH : IDLE;
      FLUSH:   if (vld_p0 && sp.spike_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state_q != IDLE);
    done = 1'b0;
    if (state_q == SWEEP && proc && last && !spike_now) done = 1'b1;
    if (state_q == FLUSH && vld_p0 && sp.spike_ready)   done = 1'b1;
  end

  // ---- control registers: sweep index, threshold, overrun, spike slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      thr_q      <= THR_INIT;
      overrun_q  <= 1'b0;
      vld_p0     <= 1'b0;
      spk_idx_p0 <= '0;
    end else begin
      if (state_q == IDLE && tick) idx_q <= '0;
      else if (proc)               idx_q <= idx_q + IW'(1);
      if (thr_we) thr_q <= thr_data;
      // busy is still high on the done cycle, so a coincident tick lands here.
      if (tick && busy) overrun_q <= 1'b1;
      // A new spike reloads the slot even while the old one is being accepted.
      if (spike_now) begin
        vld_p0     <= 1'b1;
        spk_idx_p0 <= idx_q;
      end else if (vld_p0 && sp.spike_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // ---- per-neuron state: membrane, current, refractory ----
  // cur is read before this edge's stim write lands, so a write to the neuron
  // under update applies from the next timestep.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        u_q[i]   <= '0;
        cur_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      if (stim_we) cur_q[stim_addr] <= stim_data;
      if (proc) begin
        if (ref_cur != '0) begin
          u_q[idx_q]   <= '0;
          ref_q[idx_q] <= ref_cur - RW'(1);
        end else if (fire) begin
          u_q[idx_q]   <= '0;
          ref_q[idx_q] <= RW'(REFRAC);
        end else begin
          u_q[idx_q]   <= v_sat;
        end
      end
    end
  end

`ifdef LIF_SCHED_SPIKE_COUNT_EN
  logic [IW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (state_q == IDLE && tick) cnt_q <= '0;
    else if (spike_now)               cnt_q <= cnt_q + (IW+1)'(1);
  end
  assign spike_count = cnt_q;
`endif

  assign sp.spike_valid = vld_p0;
  assign sp.spike_idx   = spk_idx_p0;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_lif_sched.sv
// tb_lif_sched: directed bench for lif_sched with a spike scoreboard.
module tb_lif_sched;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst, tick, stim_we, thr_we;
  logic [IW-1:0] stim_addr;
  logic [7:0]    stim_data, thr_data;
  logic          busy, done, overrun;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  logic [IW:0]   spike_count;
`endif

  lif_sched_if #(.IDX_W(IW)) sif ();

  lif_sched dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .stim_we   (stim_we),
    .stim_addr (stim_addr),
    .stim_data (stim_data),
    .thr_we    (thr_we),
    .thr_data  (thr_data),
    .sp        (sif),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    ,
    .spike_count (spike_count)
`endif
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  int            exp_q[$];
  int            exp_v;
  int            done_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [IW-1:0] prev_idx = '0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted spike, checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid_held", sif.spike_valid, 1);
        chk("stall_idx_stable", sif.spike_idx, prev_idx);
      end
      if (done) done_cnt++;
      if (sif.spike_valid && sif.spike_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spike_unexpected: got idx %0d, required no spike", sif.spike_idx);
        end else begin
          exp_v = exp_q.pop_front();
          chk("spike_idx", sif.spike_idx, exp_v);
        end
      end
    end
    prev_stall = !rst && sif.spike_valid && !sif.spike_ready;
    prev_idx   = sif.spike_idx;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic write_cur(input int a, input int d);
    stim_we   = 1'b1;
    stim_addr = IW'(a);
    stim_data = 8'(d);
    step();
    stim_we   = 1'b0;
  endtask

  task automatic write_thr(input int d);
    thr_we   = 1'b1;
    thr_data = 8'(d);
    step();
    thr_we   = 1'b0;
  endtask

  // cyc = 1 on the cycle right after the tick edge.
  task automatic wait_done(input string nm, output int cyc);
    cyc = 1;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    chk({nm, "_done_seen"}, done, 1);
  endtask

  task automatic sweep(input string nm, input int exp_cyc);
    int c, d0;
    d0 = done_cnt;
    pulse_tick();
    wait_done(nm, c);
    chk({nm, "_latency"}, c, exp_cyc);
    step();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_valid"}, sif.spike_valid, 0);
    chk({nm, "_idx"}, sif.spike_idx, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int c, d0;
    rst = 1'b1; tick = 1'b0; stim_we = 1'b0; thr_we = 1'b0;
    stim_addr = '0; stim_data = '0; thr_data = '0;
    sif.spike_ready = 1'b1;

    do_reset(2);
    chk_idle_outputs("reset");

    // Reset mid-sweep with a pending spike; threshold must return to 200.
    write_thr(255);
    for (int i = 0; i < N; i++) write_cur(i, 255);
    sif.spike_ready = 1'b0;
    pulse_tick();
    repeat (3) step();
    chk("pre_rst_pending", sif.spike_valid, 1);
    do_reset(2);
    chk_idle_outputs("mid_rst");
    sif.spike_ready = 1'b1;
    write_cur(2, 200);
    exp_q.push_back(2);
    sweep("post_rst", 8);
    chk("post_rst_queue", exp_q.size(), 0);

    // Integration + refractory: cur[3] = 120.
    do_reset(2);
    write_cur(3, 120);
    sweep("t1", 8);
    sweep("t2", 8);
    exp_q.push_back(3);
    sweep("t3", 8);
    chk("t3_queue", exp_q.size(), 0);
    sweep("t4", 8);
    sweep("t5", 8);
    sweep("t6", 8);
    sweep("t7", 8);
    chk("t7_no_spike", exp_q.size(), 0);
    exp_q.push_back(3);
    sweep("t8", 8);
    chk("t8_queue", exp_q.size(), 0);

    // Saturation and backpressure: every neuron fires, consumer stalls.
    do_reset(2);
    write_thr(255);
    for (int i = 0; i < N; i++) write_cur(i, 255);
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    sif.spike_ready = 1'b0;
    d0 = done_cnt;
    pulse_tick();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", sif.spike_valid, 1);
      chk("bp_idx0", sif.spike_idx, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    sif.spike_ready = 1'b1;
    wait_done("bp", c);
    chk("bp_flush_pending", exp_q.size(), 1);
    chk("bp_flush_idx", sif.spike_idx, 7);
    step();
    chk("bp_idle", busy, 0);
    chk("bp_queue", exp_q.size(), 0);
    chk("bp_done_count", done_cnt - d0, 1);
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    chk("bp_spike_count", spike_count, 8);
`endif

    // Overrun: second tick 3 cycles into a sweep.
    do_reset(2);
    d0 = done_cnt;
    pulse_tick();
    repeat (2) step();
    pulse_tick();
    chk("ovr_set", overrun, 1);
    wait_done("ovr", c);
    step();
    chk("ovr_idle", busy, 0);
    repeat (10) step();
    chk("ovr_no_resweep", busy, 0);
    chk("ovr_single_done", done_cnt - d0, 1);
    chk("ovr_sticky", overrun, 1);

    // Tick coincident with done is ignored but flagged.
    do_reset(2);
    chk("coin_clear", overrun, 0);
    pulse_tick();
    wait_done("coin", c);
    pulse_tick();
    chk("coin_overrun", overrun, 1);
    chk("coin_ignored", busy, 0);

    // Same-cycle stim write to the neuron under update.
    do_reset(2);
    pulse_tick();
    repeat (5) step();
    write_cur(5, 250);
    wait_done("wr1", c);
    step();
    chk("wr1_no_spike", exp_q.size(), 0);
    exp_q.push_back(5);
    sweep("wr2", 8);
    chk("wr2_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
